// File: rtl/mem_cmd_master.sv
// Host byte-stream command initiator for the parameter/register memory.
// Opcodes: 'W' addr data, 'R' addr, 'B' addr count; status bytes ACK 0x06, NAK 0x15, RANGE 0xEE.
module mem_cmd_master #(
  parameter int ADDR_MAX = 84,
  parameter int TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       mem_en,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       busy,
  output logic       err,
  output logic [2:0] dbg_state
);

  // Handshakes: a byte moves on a posedge where valid && ready; the sender keeps
  // data stable while valid is high and ready is low, and never withdraws valid.

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_ARG  = 3'd2,
    WRITE    = 3'd3,
    READ     = 3'd4,
    SEND     = 3'd5,
    RESP     = 3'd6
  } state_t;

  localparam logic [7:0] OP_W     = 8'h57;
  localparam logic [7:0] OP_R     = 8'h52;
  localparam logic [7:0] OP_B     = 8'h42;
  localparam logic [7:0] ST_ACK   = 8'h06;
  localparam logic [7:0] ST_NAK   = 8'h15;
  localparam logic [7:0] ST_RANGE = 8'hEE;
  localparam logic [8:0] ADDR_LIM = 9'(ADDR_MAX);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  state_t     state, state_next;
  logic [7:0] opcode, addr, data, remaining, timer;
  logic [7:0] addr_hold, wdata_hold, tx_q;
  logic [8:0] burst_end;
  logic       take, err_c, resp_load;
  logic [7:0] resp_code;

  assign take      = rx_valid && rx_ready;
  // Last address of a burst, widened so a large addr+count cannot wrap into range.
  assign burst_end = {1'b0, addr} + {1'b0, rx_data} - 9'd1;

  always_comb begin
    state_next = state;
    err_c      = 1'b0;
    resp_load  = 1'b0;
    resp_code  = 8'h00;
    case (state)
      IDLE: begin
        if (take) begin
          if (rx_data == OP_W || rx_data == OP_R || rx_data == OP_B) begin
            state_next = GET_ADDR;
          end else begin
            state_next = RESP; resp_load = 1'b1; resp_code = ST_NAK; err_c = 1'b1;
          end
        end
      end
      GET_ADDR: begin
        if (take) begin
          if (opcode != OP_R) begin
            state_next = GET_ARG;
          end else if ({1'b0, rx_data} > ADDR_LIM) begin
            state_next = RESP; resp_load = 1'b1; resp_code = ST_RANGE; err_c = 1'b1;
          end else begin
            state_next = READ;
          end
        end else if (timer == TO_LAST) begin
          state_next = IDLE; err_c = 1'b1;
        end
      end
      GET_ARG: begin
        if (take) begin
          if (opcode == OP_W) begin
            if ({1'b0, addr} > ADDR_LIM) begin
              state_next = RESP; resp_load = 1'b1; resp_code = ST_RANGE; err_c = 1'b1;
            end else begin
              state_next = WRITE;
            end
          end else if (rx_data == 8'h00) begin
            state_next = RESP; resp_load = 1'b1; resp_code = ST_NAK; err_c = 1'b1;
          end else if (burst_end > ADDR_LIM) begin
            state_next = RESP; resp_load = 1'b1; resp_code = ST_RANGE; err_c = 1'b1;
          end else begin
            state_next = READ;
          end
        end else if (timer == TO_LAST) begin
          state_next = IDLE; err_c = 1'b1;
        end
      end
      WRITE: begin
        state_next = RESP; resp_load = 1'b1; resp_code = ST_ACK;
      end
      READ: state_next = SEND;
      SEND: if (tx_ready) state_next = (remaining == 8'd1) ? IDLE : READ;
      RESP: if (tx_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // rx_ready is gated by reset so nothing is accepted while the block is held.
  assign rx_ready  = reset && (state == IDLE || state == GET_ADDR || state == GET_ARG);
  assign err       = err_c;
  assign mem_en    = (state == WRITE) || (state == READ);
  assign mem_we    = (state == WRITE);
  assign mem_addr  = mem_en ? addr : addr_hold;
  assign mem_wdata = (state == WRITE) ? data : wdata_hold;
  assign tx_valid  = (state == SEND) || (state == RESP);
  assign tx_data   = tx_q;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      opcode     <= 8'h00;
      addr       <= 8'h00;
      data       <= 8'h00;
      remaining  <= 8'h00;
      timer      <= 8'h00;
      addr_hold  <= 8'h00;
      wdata_hold <= 8'h00;
      tx_q       <= 8'h00;
    end else begin
      state <= state_next;
      if (take || !(state == GET_ADDR || state == GET_ARG)) timer <= 8'h00;
      else timer <= timer + 8'd1;
      if (take) begin
        case (state)
          IDLE:     opcode <= rx_data;
          GET_ADDR: begin addr <= rx_data; remaining <= 8'd1; end
          GET_ARG:  begin data <= rx_data; remaining <= rx_data; end
          default:  ;
        endcase
      end
      if (resp_load) tx_q <= resp_code;
      if (state == READ) tx_q <= mem_rdata;
      if (mem_en) addr_hold <= addr;
      if (state == WRITE) wdata_hold <= data;
      if (state == SEND && tx_ready) begin
        remaining <= remaining - 8'd1;
        if (addr != 8'hFF) addr <= addr + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_cmd_master.sv
// Directed bench for mem_cmd_master: behavioural memory, tx scoreboard queue,
// cycle-accurate checks of write/read/burst timing, rejections, timeout, stall and reset.
module tb_mem_cmd_master;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       err;
  logic [2:0] dbg_state;

  logic [7:0]  mem [0:255];
  logic [7:0]  exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned mem_en_cnt = 0;
  int unsigned wr_cnt = 0;
  int unsigned err_cnt = 0;
  logic        stall_prev;
  logic [7:0]  hold_val;

  mem_cmd_master #(.ADDR_MAX(84), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] preload(input int a);
    case (a)
      0:  return 8'h11;
      1:  return 8'h22;
      2:  return 8'h33;
      3:  return 8'h44;
      16: return 8'h77;
      79: return 8'h68;
      80: return 8'h01;
      84: return 8'h5A;
      default: return 8'h00;
    endcase
  endfunction

  // memory model, reloaded with the preload image while reset is held
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= preload(i);
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (mem_en) mem_en_cnt <= mem_en_cnt + 1;
    if (mem_en && mem_we) wr_cnt <= wr_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample at the falling edge: scoreboard any tx byte about to complete and
  // verify tx_data held steady across a stalled cycle.
  task automatic sample();
    @(negedge clk);
    if (stall_prev && tx_valid) check("tx_hold", tx_data, hold_val);
    if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL tx_extra: observed %02h required no byte", tx_data);
      end else begin
        check("tx_byte", tx_data, exp_q.pop_front());
      end
    end
    stall_prev = tx_valid && !tx_ready;
    hold_val   = tx_data;
  endtask

  task automatic cycle();
    sample();
    tick();
  endtask

  // driver
  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!acc && n < 20) begin
      sample();
      acc = rx_ready;
      tick();
      n++;
    end
    rx_valid = 1'b0;
    check("rx_accept", acc, 1'b1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      cycle();
      n++;
    end
    check(tag, (exp_q.size() == 0 && !busy), 1'b1);
  endtask

  task automatic wait_tx_valid(input string tag);
    logic got;
    int   n;
    got = 1'b0;
    n = 0;
    while (!got && n < 20) begin
      sample();
      got = tx_valid;
      if (!got) tick();
      n++;
    end
    check(tag, got, 1'b1);
  endtask

  initial begin
    int unsigned e0, m0, w0, m1;
    logic [7:0] burst_bytes [4];
    burst_bytes[0] = 8'h11; burst_bytes[1] = 8'h22;
    burst_bytes[2] = 8'h33; burst_bytes[3] = 8'h44;
    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    stall_prev = 1'b0; hold_val = 8'h00;

    // reset state, with a valid opcode offered to prove nothing is accepted
    tick(); tick();
    rx_valid = 1'b1; rx_data = 8'h57;
    sample();
    check("rst_rx_ready", rx_ready, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 8'h00);
    check("rst_mem_wdata", mem_wdata, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_state", dbg_state, 3'd0);
    tick();
    rx_valid = 1'b0;
    reset = 1'b1;
    tick();
    sample();
    check("idle_rx_ready", rx_ready, 1'b1);
    check("idle_busy", busy, 1'b0);
    tick();

    // W 0x52 0x03 -> single write cycle, ACK
    e0 = err_cnt; m0 = mem_en_cnt; w0 = wr_cnt;
    exp_q.push_back(8'h06);
    send_byte(8'h57); send_byte(8'h52); send_byte(8'h03);
    sample();
    check("w_en", mem_en, 1'b1);
    check("w_we", mem_we, 1'b1);
    check("w_addr", mem_addr, 8'h52);
    check("w_data", mem_wdata, 8'h03);
    tick();
    sample();
    check("w_ack_valid", tx_valid, 1'b1);
    check("w_ack_rx_ready", rx_ready, 1'b0);
    tick();
    drain("w_drain");
    check("w_one_write", wr_cnt - w0, 1);
    check("w_one_en", mem_en_cnt - m0, 1);
    check("w_no_err", err_cnt - e0, 0);

    // R 0x52 -> read cycle then data two cycles after the addr byte
    exp_q.push_back(8'h03);
    send_byte(8'h52); send_byte(8'h52);
    sample();
    check("r_en", mem_en, 1'b1);
    check("r_we", mem_we, 1'b0);
    check("r_addr", mem_addr, 8'h52);
    check("r_tx_early", tx_valid, 1'b0);
    tick();
    sample();
    check("r_tx_valid", tx_valid, 1'b1);
    check("r_tx_data", tx_data, 8'h03);
    tick();
    drain("r_drain");

    // B 79,2 with tx_ready high -> 0x68, 0x01 at one byte per two cycles
    exp_q.push_back(8'h68); exp_q.push_back(8'h01);
    send_byte(8'h42); send_byte(8'h4F); send_byte(8'h02);
    sample();
    check("b_rd0_en", mem_en, 1'b1);
    check("b_rd0_addr", mem_addr, 8'h4F);
    check("b_rd0_tx", tx_valid, 1'b0);
    tick();
    sample();
    check("b_tx0_valid", tx_valid, 1'b1);
    tick();
    sample();
    check("b_rd1_en", mem_en, 1'b1);
    check("b_rd1_addr", mem_addr, 8'h50);
    check("b_rd1_tx", tx_valid, 1'b0);
    tick();
    sample();
    check("b_tx1_valid", tx_valid, 1'b1);
    check("b_tx1_busy", busy, 1'b1);
    tick();
    sample();
    check("b_done_busy", busy, 1'b0);
    tick();
    check("b_q_empty", exp_q.size(), 0);

    // R 85 -> RANGE, err, no memory access
    e0 = err_cnt; m0 = mem_en_cnt;
    exp_q.push_back(8'hEE);
    send_byte(8'h52); send_byte(8'h55);
    drain("r85_drain");
    check("r85_err", err_cnt - e0, 1);
    check("r85_no_en", mem_en_cnt - m0, 0);

    // B 84,2 -> RANGE
    e0 = err_cnt; m0 = mem_en_cnt;
    exp_q.push_back(8'hEE);
    send_byte(8'h42); send_byte(8'h54); send_byte(8'h02);
    drain("b84_2_drain");
    check("b84_2_err", err_cnt - e0, 1);
    check("b84_2_no_en", mem_en_cnt - m0, 0);

    // B 84,1 -> legal single byte
    e0 = err_cnt; m0 = mem_en_cnt;
    exp_q.push_back(8'h5A);
    send_byte(8'h42); send_byte(8'h54); send_byte(8'h01);
    drain("b84_1_drain");
    check("b84_1_no_err", err_cnt - e0, 0);
    check("b84_1_one_en", mem_en_cnt - m0, 1);

    // B 10,0 -> NAK
    e0 = err_cnt; m0 = mem_en_cnt;
    exp_q.push_back(8'h15);
    send_byte(8'h42); send_byte(8'h0A); send_byte(8'h00);
    drain("b_cnt0_drain");
    check("b_cnt0_err", err_cnt - e0, 1);
    check("b_cnt0_no_en", mem_en_cnt - m0, 0);

    // unknown opcode then a good read
    e0 = err_cnt;
    exp_q.push_back(8'h15);
    send_byte(8'h33);
    drain("bad_op_drain");
    check("bad_op_err", err_cnt - e0, 1);
    check("bad_op_idle", busy, 1'b0);
    e0 = err_cnt;
    exp_q.push_back(8'h68);
    send_byte(8'h52); send_byte(8'h4F);
    drain("after_bad_drain");
    check("after_bad_no_err", err_cnt - e0, 0);

    // timeout: W addr then silence
    e0 = err_cnt; m0 = mem_en_cnt; w0 = wr_cnt;
    send_byte(8'h57); send_byte(8'h10);
    repeat (200) cycle();
    check("to_still_busy", busy, 1'b1);
    check("to_no_err_yet", err_cnt - e0, 0);
    repeat (60) cycle();
    check("to_idle", busy, 1'b0);
    check("to_err", err_cnt - e0, 1);
    check("to_no_write", wr_cnt - w0, 0);
    check("to_no_en", mem_en_cnt - m0, 0);
    exp_q.push_back(8'h77);
    send_byte(8'h52); send_byte(8'h10);
    drain("to_read_drain");

    // B 0,4 with ten stalled cycles per byte
    tx_ready = 1'b0;
    m0 = mem_en_cnt;
    for (int k = 0; k < 4; k++) exp_q.push_back(burst_bytes[k]);
    send_byte(8'h42); send_byte(8'h00); send_byte(8'h04);
    for (int k = 0; k < 4; k++) begin
      wait_tx_valid("stall_valid");
      check("stall_data", tx_data, burst_bytes[k]);
      repeat (10) begin
        tick();
        sample();
      end
      tick();
      tx_ready = 1'b1;
      sample();
      tick();
      tx_ready = 1'b0;
    end
    drain("stall_drain");
    check("stall_reads", mem_en_cnt - m0, 4);

    // reset in the middle of a stalled burst
    m0 = mem_en_cnt;
    exp_q.push_back(8'h11);
    send_byte(8'h42); send_byte(8'h00); send_byte(8'h04);
    wait_tx_valid("mid_valid");
    reset = 1'b0;
    #1;
    check("mid_rst_tx_valid", tx_valid, 1'b0);
    check("mid_rst_tx_data", tx_data, 8'h00);
    check("mid_rst_mem_en", mem_en, 1'b0);
    check("mid_rst_mem_we", mem_we, 1'b0);
    check("mid_rst_mem_addr", mem_addr, 8'h00);
    check("mid_rst_mem_wdata", mem_wdata, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_rx_ready", rx_ready, 1'b0);
    check("mid_rst_err", err, 1'b0);
    m1 = mem_en_cnt;
    check("mid_reads_before", m1 - m0, 1);
    void'(exp_q.pop_front());
    tick(); tick();
    reset = 1'b1;
    repeat (5) cycle();
    check("mid_no_more_en", mem_en_cnt - m1, 0);
    check("mid_after_busy", busy, 1'b0);
    check("mid_after_tx", tx_valid, 1'b0);
    check("final_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
